// File: rtl/mprf_sb_pkg.sv
// Shared defaults and helpers for the multi-port register file with scoreboard.
package mprf_sb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int NWR_DEF  = 2;
  localparam int NISS_DEF = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/mprf_wsel.sv
// Write select for one register: the highest wb port wins, then lower wb ports, then mem.
module mprf_wsel
  import mprf_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int AW     = 5,
  parameter int NWR    = NWR_DEF,
  parameter int IDX    = 1,
  parameter int BYPASS = 1
) (
  input  logic [NWR-1:0]      wb_vld,
  input  logic [NWR*AW-1:0]   wb_sel,
  input  logic [NWR*XLEN-1:0] wb_data,
  input  logic                mem_vld,
  input  logic [AW-1:0]       mem_sel,
  input  logic [XLEN-1:0]     mem_data,
  output logic                we,
  output logic [XLEN-1:0]     data,
  output logic                hit
);
  localparam logic [AW-1:0] SEL = AW'(IDX);

  always_comb begin
    we   = mem_vld && (mem_sel == SEL);
    data = mem_data;
    // Ascending scan: a later (higher) port overrides earlier matches.
    for (int i = 0; i < NWR; i++) begin
      if (wb_vld[i] && (wb_sel[i*AW +: AW] == SEL)) begin
        we   = 1'b1;
        data = wb_data[i*XLEN +: XLEN];
      end
    end
    hit = (BYPASS != 0) && we;
  end
endmodule

// File: rtl/mprf_sb.sv
// Multi-port register file with per-register busy scoreboard and optional write bypass.
module mprf_sb
  import mprf_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF,
  parameter int NISS   = NISS_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NISS-1:0]     iss_vld,
  input  logic [NISS*AW-1:0]  iss_sel,
  input  logic [NWR-1:0]      wb_vld,
  input  logic [NWR*AW-1:0]   wb_sel,
  input  logic [NWR*XLEN-1:0] wb_data,
  input  logic                mem_vld,
  input  logic [AW-1:0]       mem_sel,
  input  logic [XLEN-1:0]     mem_data,
  input  logic                flush,
  input  logic [NRD*AW-1:0]   rs0_sel,
  input  logic [NRD*AW-1:0]   rs1_sel,
  output logic [NRD*XLEN-1:0] rs0_data,
  output logic [NRD*XLEN-1:0] rs1_data,
  output logic [NRD-1:0]      rs0_rdy,
  output logic [NRD-1:0]      rs1_rdy,
  output logic [NREG-1:0]     busy
);
  logic [XLEN-1:0] regs  [NREG];
  logic [XLEN-1:0] wdata [NREG];
  logic            we    [NREG];
  logic            hit   [NREG];
  logic [NREG-1:0] busy_q, iss_hit;

  // x0 has no write path, so it stays 0 and never bypasses.
  assign we[0]    = 1'b0;
  assign hit[0]   = 1'b0;
  assign wdata[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_wsel
    mprf_wsel #(
      .XLEN(XLEN), .AW(AW), .NWR(NWR), .IDX(r), .BYPASS(BYPASS)
    ) u_wsel (
      .wb_vld  (wb_vld),
      .wb_sel  (wb_sel),
      .wb_data (wb_data),
      .mem_vld (mem_vld),
      .mem_sel (mem_sel),
      .mem_data(mem_data),
      .we      (we[r]),
      .data    (wdata[r]),
      .hit     (hit[r])
    );
  end

  always_comb begin
    iss_hit = '0;
    for (int i = 0; i < NISS; i++)
      if (iss_vld[i]) iss_hit[iss_sel[i*AW +: AW]] = 1'b1;
    iss_hit[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (we[r]) regs[r] <= wdata[r];
        // Issue is younger than a same-cycle write; flush drops all issues.
        if (flush)           busy_q[r] <= 1'b0;
        else if (iss_hit[r]) busy_q[r] <= 1'b1;
        else if (we[r])      busy_q[r] <= 1'b0;
      end
      regs[0]   <= '0;
      busy_q[0] <= 1'b0;
    end
  end

  assign busy = busy_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] s0, s1;
    assign s0 = rs0_sel[p*AW +: AW];
    assign s1 = rs1_sel[p*AW +: AW];
    assign rs0_data[p*XLEN +: XLEN] = hit[s0] ? wdata[s0] : regs[s0];
    assign rs1_data[p*XLEN +: XLEN] = hit[s1] ? wdata[s1] : regs[s1];
    assign rs0_rdy[p] = !busy_q[s0] || hit[s0];
    assign rs1_rdy[p] = !busy_q[s1] || hit[s1];
  end
endmodule
